mmio_rd_rsp_tracker: RTL and testbench

- Sits between the PCIe MMIO request path and the FME/Port feature CSR fabric.
- Forwards host MMIO read requests to the feature side and records each request's TID in an in-order tracking FIFO.
- Pairs each in-order feature read response with the recorded TID and returns a completion to the host side.
- If a feature never answers, synthesises an all-ones timeout completion so the host never hangs. Late feature responses for timed-out entries are discarded.

---
 rtl/mmio_rd_rsp_tracker.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_rd_rsp_tracker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_rd_rsp_tracker.sv
// MMIO read tracker: forwards host reads, pairs in-order feature responses with their TIDs,
// and synthesises all-ones timeout completions. Optional statistics: `define MMIO_RD_TRK_STATS_EN.
module mmio_rd_rsp_tracker #(
  parameter int TID_WIDTH      = 6,
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TID_WIDTH-1:0]  req_tid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  fwd_valid,
  input  logic                  fwd_ready,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [TID_WIDTH-1:0]  cpl_tid,
  output logic [DATA_WIDTH-1:0] cpl_data,
  output logic                  cpl_timeout,
  output logic [15:0]           stat_timeouts,
  output logic [15:0]           stat_drops
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DC_W  = PTR_W + 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  logic [TID_WIDTH-1:0]    tid_mem_q [DEPTH];
  logic [TID_WIDTH-1:0]    tid_mem_d [DEPTH];
  logic [DC_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    cpl_valid_q, cpl_valid_d;
  logic [TID_WIDTH-1:0]    cpl_tid_q, cpl_tid_d;
  logic [DATA_WIDTH-1:0]   cpl_data_q, cpl_data_d;
  logic                    cpl_timeout_q, cpl_timeout_d;

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    slot_free;
  logic                    drop_pending;
  logic                    push;
  logic                    rsp_fire;
  logic                    rsp_drop;
  logic                    rsp_cpl;
  logic                    to_fire;
  logic                    pop;
  logic [TID_WIDTH-1:0]    head_tid;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign slot_free    = !cpl_valid_q || cpl_ready;
  assign drop_pending = (drop_cnt_q != {DC_W{1'b0}});
  assign head_tid     = tid_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Handshake outputs are combinational and held low while reset is asserted.
  assign fwd_valid = rst_n && req_valid && !fifo_full;
  assign req_ready = rst_n && fwd_ready && !fifo_full;
  assign fwd_addr  = req_addr;
  assign rsp_ready = rst_n && slot_free && (drop_pending || !fifo_empty);

  assign push     = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign rsp_drop = rsp_fire && drop_pending;
  assign rsp_cpl  = rsp_fire && !drop_pending;
  // A real response in the expiry cycle takes precedence over the timeout.
  assign to_fire  = (to_cnt_q == TO_MAX) && !drop_pending && slot_free && !fifo_empty && !rsp_cpl;
  assign pop      = rsp_cpl || to_fire;

  assign cpl_valid   = cpl_valid_q;
  assign cpl_tid     = cpl_tid_q;
  assign cpl_data    = cpl_data_q;
  assign cpl_timeout = cpl_timeout_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tid_mem_d     = tid_mem_q;
    drop_cnt_d    = drop_cnt_q;
    to_cnt_d      = to_cnt_q;
    cpl_valid_d   = cpl_valid_q;
    cpl_tid_d     = cpl_tid_q;
    cpl_data_d    = cpl_data_q;
    cpl_timeout_d = cpl_timeout_q;

    if (push) begin
      tid_mem_d[wr_ptr_q[PTR_W-1:0]] = req_tid;
      wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Head age: restarts for each new head, saturates at the timeout threshold.
    if (fifo_empty || pop) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (to_fire) begin
      drop_cnt_d = drop_cnt_q + DC_W'(1);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - DC_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (rsp_cpl) begin
      cpl_valid_d   = 1'b1;
      cpl_tid_d     = head_tid;
      cpl_data_d    = rsp_data;
      cpl_timeout_d = 1'b0;
    end else if (to_fire) begin
      cpl_valid_d   = 1'b1;
      cpl_tid_d     = head_tid;
      cpl_data_d    = {DATA_WIDTH{1'b1}};
      cpl_timeout_d = 1'b1;
    end else if (cpl_ready) begin
      cpl_valid_d   = 1'b0;
    end else begin
      cpl_valid_d   = cpl_valid_q;
    end
  end

  // Tracking FIFO, drop/timeout counters and completion slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= {(PTR_W + 1){1'b0}};
      rd_ptr_q      <= {(PTR_W + 1){1'b0}};
      tid_mem_q     <= '{default: {TID_WIDTH{1'b0}}};
      drop_cnt_q    <= {DC_W{1'b0}};
      to_cnt_q      <= {TO_W{1'b0}};
      cpl_valid_q   <= 1'b0;
      cpl_tid_q     <= {TID_WIDTH{1'b0}};
      cpl_data_q    <= {DATA_WIDTH{1'b0}};
      cpl_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tid_mem_q     <= tid_mem_d;
      drop_cnt_q    <= drop_cnt_d;
      to_cnt_q      <= to_cnt_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_tid_q     <= cpl_tid_d;
      cpl_data_q    <= cpl_data_d;
      cpl_timeout_q <= cpl_timeout_d;
    end
  end

`ifdef MMIO_RD_TRK_STATS_EN
  logic [15:0] stat_to_q, stat_to_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  // Saturating event counters.
  always_comb begin
    stat_to_d   = stat_to_q;
    stat_drop_d = stat_drop_q;
    if (to_fire && (stat_to_q != 16'hFFFF)) begin
      stat_to_d = stat_to_q + 16'd1;
    end else begin
      stat_to_d = stat_to_q;
    end
    if (rsp_drop && (stat_drop_q != 16'hFFFF)) begin
      stat_drop_d = stat_drop_q + 16'd1;
    end else begin
      stat_drop_d = stat_drop_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_to_q   <= 16'h0000;
      stat_drop_q <= 16'h0000;
    end else begin
      stat_to_q   <= stat_to_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_timeouts = stat_to_q;
  assign stat_drops    = stat_drop_q;
`else
  assign stat_timeouts = 16'h0000;
  assign stat_drops    = 16'h0000;
`endif

endmodule

// File: tb/tb_mmio_rd_rsp_tracker.sv
// Scoreboard bench for mmio_rd_rsp_tracker (TIMEOUT_CYCLES=16, DEPTH=8).
module tb_mmio_rd_rsp_tracker;
  localparam int TW  = 6;
  localparam int AW  = 20;
  localparam int DW  = 64;
  localparam int DEP = 8;
  localparam int TO  = 16;
`ifdef MMIO_RD_TRK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [TW-1:0] req_tid;
  logic [AW-1:0] req_addr;
  logic          fwd_valid, fwd_ready;
  logic [AW-1:0] fwd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          cpl_valid, cpl_ready;
  logic [TW-1:0] cpl_tid;
  logic [DW-1:0] cpl_data;
  logic          cpl_timeout;
  logic [15:0]   stat_timeouts, stat_drops;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
    logic          to;
  } cpl_t;

  cpl_t exp_q[$];
  int vectors = 0;
  int errors  = 0;
  int exp_timeouts = 0;
  int exp_drops = 0;

  mmio_rd_rsp_tracker #(
    .TID_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid), .req_addr(req_addr),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tid(cpl_tid), .cpl_data(cpl_data),
    .cpl_timeout(cpl_timeout), .stat_timeouts(stat_timeouts), .stat_drops(stat_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completion monitor: every accepted completion must match the scoreboard head.
  always @(negedge clk) begin
    cpl_t e;
    if (rst_n === 1'b1 && cpl_valid === 1'b1 && cpl_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cpl: got tid=%h data=%h to=%b, required no completion",
                 cpl_tid, cpl_data, cpl_timeout);
      end else begin
        e = exp_q.pop_front();
        if ({cpl_tid, cpl_data, cpl_timeout} !== e) begin
          errors++;
          $display("FAIL cpl_match: got tid=%h data=%h to=%b, required tid=%h data=%h to=%b",
                   cpl_tid, cpl_data, cpl_timeout, e.tid, e.data, e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [TW-1:0] tid, input logic [AW-1:0] addr);
    req_valid = 1'b1;
    req_tid   = tid;
    req_addr  = addr;
    #1;
    vectors++;
    if ({fwd_valid, req_ready, fwd_addr} !== {1'b1, 1'b1, addr}) begin
      errors++;
      $display("FAIL req_handshake: got fwd_valid=%b req_ready=%b fwd_addr=%h, required 1 1 %h",
               fwd_valid, req_ready, fwd_addr, addr);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [DW-1:0] data, input bit drop, input logic [TW-1:0] tid);
    int n;
    rsp_valid = 1'b1;
    rsp_data  = data;
    if (drop) exp_drops++;
    else exp_q.push_back({tid, data, 1'b0});
    #1;
    n = 0;
    while (rsp_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_accept: got rsp_ready=%b after %0d cycles, required 1", rsp_ready, n);
    end
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d completions outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic check_stats(input string name);
    logic [15:0] et, ed;
    et = STATS ? 16'(exp_timeouts) : 16'h0000;
    ed = STATS ? 16'(exp_drops) : 16'h0000;
    vectors++;
    if ({stat_timeouts, stat_drops} !== {et, ed}) begin
      errors++;
      $display("FAIL %s: got timeouts=%0d drops=%0d, required %0d %0d",
               name, stat_timeouts, stat_drops, et, ed);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b1; fwd_ready = 1'b1; rsp_valid = 1'b1; cpl_ready = 1'b1;
    req_tid = 6'h01; req_addr = 20'h00010; rsp_data = 64'h0;
    tick();
    tick();
    vectors++;
    if ({req_ready, fwd_valid, rsp_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_forced: got req_ready=%b fwd_valid=%b rsp_ready=%b, required 000",
               req_ready, fwd_valid, rsp_ready);
    end
    vectors++;
    if ({cpl_valid, cpl_tid, cpl_data, cpl_timeout} !== {1'b0, 6'h00, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_cpl: got v=%b tid=%h data=%h to=%b, required all 0",
               cpl_valid, cpl_tid, cpl_data, cpl_timeout);
    end
    check_stats("reset_stats");
    rst_n = 1'b1; req_valid = 1'b0; rsp_valid = 1'b0;
    #1;
    vectors++;
    if ({req_ready, fwd_valid, rsp_ready} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got req_ready=%b fwd_valid=%b rsp_ready=%b, required 100",
               req_ready, fwd_valid, rsp_ready);
    end
    tick();
  endtask

  task automatic test_single_read;
    do_req(6'h2A, 20'hABCDE);
    tick();
    tick();
    send_rsp(64'h1122_3344_5566_7788, 1'b0, 6'h2A);
    vectors++;
    if ({cpl_valid, cpl_tid, cpl_data, cpl_timeout} !== {1'b1, 6'h2A, 64'h1122_3344_5566_7788, 1'b0}) begin
      errors++;
      $display("FAIL single_latency: got v=%b tid=%h data=%h to=%b, required 1 2a 1122334455667788 0",
               cpl_valid, cpl_tid, cpl_data, cpl_timeout);
    end
    wait_drain(5);
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEP; i++) do_req(6'(i), 20'h00100 + 20'(i));
    req_valid = 1'b1;
    req_tid   = 6'h08;
    #1;
    vectors++;
    if ({req_ready, fwd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL full_block: got req_ready=%b fwd_valid=%b, required 00", req_ready, fwd_valid);
    end
    req_valid = 1'b0;
    for (int i = 0; i < DEP; i++) send_rsp(64'h100 + 64'(i), 1'b0, 6'(i));
    wait_drain(5);
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_release: got req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_timeout;
    int n;
    do_req(6'h05, 20'h00500);
    exp_q.push_back({6'h05, {DW{1'b1}}, 1'b1});
    exp_timeouts++;
    n = 0;
    while (cpl_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", n, TO + 1);
    end
    check_stats("timeout_stat");
    tick();
    send_rsp(64'hDEAD_BEEF_0000_0005, 1'b1, 6'h05);
    check_stats("drop_stat");
    vectors++;
    if (rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: got rsp_ready=%b, required 0", rsp_ready);
    end
    wait_drain(5);
  endtask

  task automatic test_race;
    do_req(6'h09, 20'h00900);
    repeat (TO) tick();
    send_rsp(64'hCAFE_F00D_1234_5678, 1'b0, 6'h09);
    vectors++;
    if ({cpl_valid, cpl_tid, cpl_timeout} !== {1'b1, 6'h09, 1'b0}) begin
      errors++;
      $display("FAIL race_cpl: got v=%b tid=%h to=%b, required 1 09 0", cpl_valid, cpl_tid, cpl_timeout);
    end
    vectors++;
    if (rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL race_drop: got rsp_ready=%b, required 0", rsp_ready);
    end
    check_stats("race_stat");
    wait_drain(5);
  endtask

  task automatic test_backpressure;
    cpl_ready = 1'b0;
    do_req(6'h11, 20'h01100);
    do_req(6'h12, 20'h01200);
    do_req(6'h13, 20'h01300);
    send_rsp(64'hA0A0_0000_0000_0011, 1'b0, 6'h11);
    rsp_valid = 1'b1;
    rsp_data  = 64'hA0A0_0000_0000_0012;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({cpl_valid, cpl_tid, cpl_data, cpl_timeout} !== {1'b1, 6'h11, 64'hA0A0_0000_0000_0011, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got v=%b tid=%h data=%h to=%b", i,
                 cpl_valid, cpl_tid, cpl_data, cpl_timeout);
      end
      vectors++;
      if (rsp_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_rsp_ready: cycle %0d got %b, required 0", i, rsp_ready);
      end
      tick();
    end
    cpl_ready = 1'b1;
    send_rsp(64'hA0A0_0000_0000_0012, 1'b0, 6'h12);
    send_rsp(64'hA0A0_0000_0000_0013, 1'b0, 6'h13);
    wait_drain(10);
  endtask

  task automatic test_reset_mid;
    cpl_ready = 1'b1;
    for (int i = 0; i < 4; i++) do_req(6'h20 + 6'(i), 20'h02000 + 20'(i));
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_timeouts = 0;
    exp_drops = 0;
    #1;
    vectors++;
    if ({req_ready, rsp_ready, cpl_valid} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset: got req_ready=%b rsp_ready=%b cpl_valid=%b, required 100",
               req_ready, rsp_ready, cpl_valid);
    end
    check_stats("mid_reset_stat");
    repeat (2 * TO + 8) tick();
    vectors++;
    if ({cpl_valid, rsp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_idle: got cpl_valid=%b rsp_ready=%b, required 00", cpl_valid, rsp_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_tid = '0; req_addr = '0; fwd_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = '0; cpl_ready = 1'b1;
    test_reset();
    test_single_read();
    test_fill();
    test_timeout();
    test_race();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
